rgb_sram_writer: RTL and testbench

RGB_SRAM_WRITER -- requirements
Module: rgb_sram_writer

---
 rtl/rgb_sram_writer_if.sv | 26 ++
 rtl/rgb_sram_writer.sv | 118 +++++++++++
 tb/tb_rgb_sram_writer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_sram_writer_if.sv
// Pixel stream, frame control and SRAM write bus for rgb_sram_writer.
// The master drives frame requests and pixels; the slave owns the SRAM write port.
interface rgb_sram_writer_if;
  logic        Start;
  logic [17:0] SRAM_base_address;
  logic        Pixel_valid;
  logic [7:0]  Pixel_R;
  logic [7:0]  Pixel_G;
  logic [7:0]  Pixel_B;
  logic        Pixel_ready;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        Busy;
  logic        Done;

  modport master (
    output Start, SRAM_base_address, Pixel_valid, Pixel_R, Pixel_G, Pixel_B,
    input  Pixel_ready, SRAM_address, SRAM_write_data, SRAM_we_n, Busy, Done
  );

  modport slave (
    input  Start, SRAM_base_address, Pixel_valid, Pixel_R, Pixel_G, Pixel_B,
    output Pixel_ready, SRAM_address, SRAM_write_data, SRAM_we_n, Busy, Done
  );
endinterface

// File: rtl/rgb_sram_writer.sv
// Packs pairs of 24-bit RGB pixels into three 16-bit SRAM words and writes one frame
// starting at a base word address latched on Start.
module rgb_sram_writer #(
  parameter int unsigned PIXEL_COUNT = 76800
) (
  input logic          Clock,
  input logic          Resetn,
  rgb_sram_writer_if.slave bus
);

  localparam logic [17:0] PixTotal = 18'(PIXEL_COUNT);

  typedef enum logic [2:0] {
    StIdle, StWaitP0, StWaitP1, StWr0, StWr1, StWr2, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [17:0] base_q, base_d;
  logic [17:0] pix_cnt_q, pix_cnt_d;
  logic [17:0] word_off_q, word_off_d;
  logic [23:0] p0_q, p0_d;
  logic [23:0] p1_q, p1_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        we_n_q, we_n_d;
  logic [23:0] pixel_in;

  assign pixel_in = {bus.Pixel_R, bus.Pixel_G, bus.Pixel_B};

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    pix_cnt_d  = pix_cnt_q;
    word_off_d = word_off_q;
    p0_d       = p0_q;
    p1_d       = p1_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_n_d     = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          base_d     = bus.SRAM_base_address;
          pix_cnt_d  = '0;
          word_off_d = '0;
          state_d    = StWaitP0;
        end
      end
      StWaitP0: begin
        if (bus.Pixel_valid) begin
          p0_d    = pixel_in;
          state_d = StWaitP1;
        end
      end
      StWaitP1: begin
        // Output registers are loaded one edge ahead so W0 is on the bus during WR0.
        if (bus.Pixel_valid) begin
          p1_d    = pixel_in;
          addr_d  = base_q + word_off_q;
          data_d  = p0_q[23:8];
          we_n_d  = 1'b0;
          state_d = StWr0;
        end
      end
      StWr0: begin
        addr_d  = base_q + word_off_q + 18'd1;
        data_d  = {p0_q[7:0], p1_q[23:16]};
        we_n_d  = 1'b0;
        state_d = StWr1;
      end
      StWr1: begin
        addr_d  = base_q + word_off_q + 18'd2;
        data_d  = p1_q[15:0];
        we_n_d  = 1'b0;
        state_d = StWr2;
      end
      StWr2: begin
        pix_cnt_d  = pix_cnt_q + 18'd2;
        word_off_d = word_off_q + 18'd3;
        state_d    = (pix_cnt_d == PixTotal) ? StDone : StWaitP0;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= StIdle;
      base_q     <= '0;
      pix_cnt_q  <= '0;
      word_off_q <= '0;
      p0_q       <= '0;
      p1_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      pix_cnt_q  <= pix_cnt_d;
      word_off_q <= word_off_d;
      p0_q       <= p0_d;
      p1_q       <= p1_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_n_q     <= we_n_d;
    end
  end

  assign bus.Pixel_ready     = (state_q == StWaitP0) || (state_q == StWaitP1);
  assign bus.Busy            = (state_q != StIdle) && (state_q != StDone);
  assign bus.Done            = (state_q == StDone);
  assign bus.SRAM_address    = addr_q;
  assign bus.SRAM_write_data = data_q;
  assign bus.SRAM_we_n       = we_n_q;

endmodule

// File: tb/tb_rgb_sram_writer.sv
// Scoreboard bench for rgb_sram_writer: expected SRAM writes are queued when a frame is
// launched and popped as the DUTs write.
module tb_rgb_sram_writer;

  logic Clock = 1'b0;
  logic Resetn = 1'b1;

  rgb_sram_writer_if ifa ();
  rgb_sram_writer_if ifb ();

  rgb_sram_writer #(.PIXEL_COUNT(4)) dut_a (.Clock(Clock), .Resetn(Resetn), .bus(ifa));
  rgb_sram_writer #(.PIXEL_COUNT(2)) dut_b (.Clock(Clock), .Resetn(Resetn), .bus(ifb));

  always #5 Clock = ~Clock;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];
  int acc_a = 0, acc_b = 0, wr_a = 0, wr_b = 0, done_a = 0, done_b = 0, we_run = 0;
  logic drv_start_a = 1'b0;
  logic inj_start = 1'b0;
  logic inj_en = 1'b0;
  logic [23:0] pix_tab [4];

  assign ifa.Start = drv_start_a | inj_start;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Accepts and Done pulses are counted on the edge that acts on them.
  always @(posedge Clock) begin
    if (ifa.Pixel_valid && ifa.Pixel_ready) acc_a++;
    if (ifb.Pixel_valid && ifb.Pixel_ready) acc_b++;
    if (ifa.Done) begin
      done_a++;
      check_eq("a_busy_in_done", {63'b0, ifa.Busy}, 64'd0);
    end
    if (ifb.Done) begin
      done_b++;
      check_eq("b_busy_in_done", {63'b0, ifb.Busy}, 64'd0);
    end
  end

  always @(negedge Clock) begin
    if (ifa.SRAM_we_n === 1'b0) begin
      wr_a++;
      if (exp_a.size() == 0)
        check_eq("a_extra_write", {30'b0, ifa.SRAM_address, ifa.SRAM_write_data}, '1);
      else
        check_eq("a_write", {30'b0, ifa.SRAM_address, ifa.SRAM_write_data}, exp_a.pop_front());
    end
    if (ifb.SRAM_we_n === 1'b0) begin
      wr_b++;
      if (exp_b.size() == 0)
        check_eq("b_extra_write", {30'b0, ifb.SRAM_address, ifb.SRAM_write_data}, '1);
      else
        check_eq("b_write", {30'b0, ifb.SRAM_address, ifb.SRAM_write_data}, exp_b.pop_front());
    end
    // Stray Start pulses in WAIT_P1 (odd accept count), WR1 and DONE.
    inj_start = inj_en && ((ifa.Pixel_ready && acc_a[0]) ||
                           (we_run == 1 && !ifa.SRAM_we_n) || ifa.Done);
    we_run = ifa.SRAM_we_n ? 0 : we_run + 1;
  end

  function automatic logic rdy(input bit sel);
    return sel ? ifb.Pixel_ready : ifa.Pixel_ready;
  endfunction

  function automatic int done_of(input bit sel);
    return sel ? done_b : done_a;
  endfunction

  task automatic drive_px(input bit sel, input logic v, input logic [23:0] pix);
    if (sel) begin
      ifb.Pixel_valid = v;
      {ifb.Pixel_R, ifb.Pixel_G, ifb.Pixel_B} = pix;
    end else begin
      ifa.Pixel_valid = v;
      {ifa.Pixel_R, ifa.Pixel_G, ifa.Pixel_B} = pix;
    end
  endtask

  task automatic drive_start(input bit sel, input logic s, input logic [17:0] base);
    if (sel) begin
      ifb.Start = s;
      ifb.SRAM_base_address = base;
    end else begin
      drv_start_a = s;
      ifa.SRAM_base_address = base;
    end
  endtask

  task automatic push_exp(input bit sel, input logic [17:0] a, input logic [15:0] d);
    if (sel) exp_b.push_back({30'b0, a, d});
    else exp_a.push_back({30'b0, a, d});
  endtask

  // Returns on the falling edge following the edge that accepted the pixel.
  task automatic send_pixel(input bit sel, input logic [23:0] pix, input int gap);
    int n = 0;
    for (int i = 0; i < gap; i++) begin
      drive_px(sel, 1'b0, pix);
      @(negedge Clock);
    end
    drive_px(sel, 1'b1, pix);
    while (rdy(sel) !== 1'b1 && n < 100) begin
      @(negedge Clock);
      n++;
    end
    if (n == 100) check_eq("ready_timeout", 64'(n), 64'd0);
    @(negedge Clock);
  endtask

  task automatic wait_done(input bit sel, input int target);
    int n = 0;
    while (done_of(sel) < target && n < 200) begin
      @(negedge Clock);
      n++;
    end
    check_eq("done_seen", {63'b0, done_of(sel) >= target}, 64'd1);
  endtask

  task automatic run_frame(input bit sel, input logic [17:0] base, input int npix,
                           input bit gaps, input string tag);
    int d0, a0, w0;
    logic [17:0] a;
    logic [23:0] p0, p1;
    d0 = done_of(sel);
    a0 = sel ? acc_b : acc_a;
    w0 = sel ? wr_b : wr_a;
    for (int n = 0; n < npix / 2; n++) begin
      p0 = pix_tab[2*n];
      p1 = pix_tab[2*n+1];
      a = base + 18'(3 * n);
      push_exp(sel, a, p0[23:8]);
      a = a + 18'd1;
      push_exp(sel, a, {p0[7:0], p1[23:16]});
      a = a + 18'd1;
      push_exp(sel, a, p1[15:0]);
    end
    @(negedge Clock);
    drive_start(sel, 1'b1, base);
    @(negedge Clock);
    drive_start(sel, 1'b0, 18'h15555);
    check_eq({tag, "_busy"}, {63'b0, sel ? ifb.Busy : ifa.Busy}, 64'd1);
    for (int i = 0; i < npix; i++) send_pixel(sel, pix_tab[i], gaps ? (i % 2) + 1 : 0);
    drive_px(sel, 1'b0, 24'h0);
    wait_done(sel, d0 + 1);
    repeat (3) @(negedge Clock);
    check_eq({tag, "_done_count"}, 64'(done_of(sel) - d0), 64'd1);
    check_eq({tag, "_accepts"}, 64'((sel ? acc_b : acc_a) - a0), 64'(npix));
    check_eq({tag, "_writes"}, 64'((sel ? wr_b : wr_a) - w0), 64'(3 * npix / 2));
    check_eq({tag, "_pending"}, 64'(sel ? exp_b.size() : exp_a.size()), 64'd0);
    check_eq({tag, "_busy_after"}, {63'b0, sel ? ifb.Busy : ifa.Busy}, 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_we_n"}, {63'b0, ifa.SRAM_we_n}, 64'd1);
    check_eq({tag, "_addr"}, {46'b0, ifa.SRAM_address}, 64'd0);
    check_eq({tag, "_data"}, {48'b0, ifa.SRAM_write_data}, 64'd0);
    check_eq({tag, "_ready"}, {63'b0, ifa.Pixel_ready}, 64'd0);
    check_eq({tag, "_busy"}, {63'b0, ifa.Busy}, 64'd0);
    check_eq({tag, "_done"}, {63'b0, ifa.Done}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, w0;
    ifb.Start = 1'b0;
    ifb.SRAM_base_address = '0;
    ifa.SRAM_base_address = '0;
    drive_px(0, 1'b0, 24'h0);
    drive_px(1, 1'b0, 24'h0);
    #3 Resetn = 1'b0;
    #1 check_reset_vals("rst");
    check_eq("rst_b_we_n", {63'b0, ifb.SRAM_we_n}, 64'd1);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;

    // Data offered while idle must never be accepted.
    for (int i = 0; i < 10; i++) begin
      drive_px(0, 1'b1, 24'hDEADBE);
      @(negedge Clock);
      check_eq("idle_ready", {63'b0, ifa.Pixel_ready}, 64'd0);
    end
    check_eq("idle_accepts", 64'(acc_a), 64'd0);

    pix_tab[0] = 24'h112233;
    pix_tab[1] = 24'h445566;
    pix_tab[2] = 24'h778899;
    pix_tab[3] = 24'hAABBCC;
    run_frame(0, 18'h00100, 4, 1'b0, "frame");
    run_frame(0, 18'h00100, 4, 1'b1, "gaps");
    inj_en = 1'b1;
    run_frame(0, 18'h00100, 4, 1'b0, "stray_start");
    inj_en = 1'b0;

    pix_tab[0] = 24'h010203;
    pix_tab[1] = 24'h040506;
    run_frame(1, 18'h3FFFE, 2, 1'b0, "wrap");

    // Reset in WR1 of pair 0: W0 and W1 appear, nothing after.
    pix_tab[0] = 24'h112233;
    pix_tab[1] = 24'h445566;
    push_exp(0, 18'h00100, 16'h1122);
    push_exp(0, 18'h00101, 16'h3344);
    @(negedge Clock);
    drive_start(0, 1'b1, 18'h00100);
    @(negedge Clock);
    drive_start(0, 1'b0, 18'h15555);
    send_pixel(0, pix_tab[0], 0);
    send_pixel(0, pix_tab[1], 0);
    @(negedge Clock);
    check_eq("wr1_we_low", {63'b0, ifa.SRAM_we_n}, 64'd0);
    #2 Resetn = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge Clock);
    Resetn = 1'b1;
    a0 = acc_a;
    w0 = wr_a;
    for (int i = 0; i < 10; i++) begin
      drive_px(0, 1'b1, 24'hABCDEF);
      @(negedge Clock);
      check_eq("post_rst_ready", {63'b0, ifa.Pixel_ready}, 64'd0);
    end
    drive_px(0, 1'b0, 24'h0);
    check_eq("post_rst_accepts", 64'(acc_a - a0), 64'd0);
    check_eq("post_rst_writes", 64'(wr_a - w0), 64'd0);
    check_eq("post_rst_pending", 64'(exp_a.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
